// File: rtl/dsp_post_pkg.sv
// dsp_post_pkg: shared constants for the DSP post-adder / P register slice.
// Holds opmode field positions, X/Z select encodings and datapath widths.
package dsp_post_pkg;

    // Datapath widths
    localparam int P_W      = 48;   // result / C / DAB width
    localparam int M_W      = 36;   // multiplier product width
    localparam int SUM_W    = 49;   // result plus carry/borrow bit
    localparam int OPMODE_W = 8;

    // Opmode field positions
    localparam int OPM_X_LSB   = 0;  // [1:0] X select
    localparam int OPM_Z_LSB   = 2;  // [3:2] Z select
    localparam int OPM_CIN_BIT = 5;  // carry-in source when CARRYINSEL="OPMODE5"
    localparam int OPM_SUB_BIT = 7;  // 1 = Z - (X + cin)

    // X multiplexer encodings
    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    // Z multiplexer encodings
    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    // Extract the X select field from an opmode word
    function automatic x_sel_e get_x_sel(input logic [OPMODE_W-1:0] opm);
        return x_sel_e'(opm[OPM_X_LSB +: 2]);
    endfunction

    // Extract the Z select field from an opmode word
    function automatic z_sel_e get_z_sel(input logic [OPMODE_W-1:0] opm);
        return z_sel_e'(opm[OPM_Z_LSB +: 2]);
    endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: optional pipeline register with clock enable and
// asynchronous active-high reset. USE_REG=0 passes d straight through
// to q; the storage element is still present but its output is ignored.
module dsp_pipe_reg #(
    parameter int WIDTH   = 1,
    parameter bit USE_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_r;

    // Storage: reset clears regardless of ce, otherwise load on ce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
        end else if (ce) begin
            data_r <= d;
        end
    end

    // Output selection between registered and bypassed data
    assign q = USE_REG ? data_r : d;

endmodule

// File: rtl/post_adder_preg.sv
// post_adder_preg: DSP post-adder with X/Z operand multiplexers,
// add/subtract with carry-in, and the P/CARRYOUT output register.
// Optional build macro: POST_ADD_PCIN_EN adds a 48-bit pcin cascade
// input selected by Z select 1; without it Z select 1 yields zero.
module post_adder_preg
    import dsp_post_pkg::*;
#(
    parameter int    PREG       = 1,
    parameter int    OPMODEREG  = 1,
    parameter int    CARRYINREG = 1,
    parameter string CARRYINSEL = "OPMODE5"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cep,
    input  logic                ceopmode,
    input  logic                cecarryin,
    input  logic [OPMODE_W-1:0] opmode,
    input  logic [M_W-1:0]      m,
    input  logic [P_W-1:0]      dab,
    input  logic [P_W-1:0]      c,
`ifdef POST_ADD_PCIN_EN
    input  logic [P_W-1:0]      pcin,
`endif
    input  logic                carryin,
    output logic [P_W-1:0]      p,
    output logic [P_W-1:0]      pcout,
    output logic                carryout,
    output logic                carryoutf
);

    localparam bit USE_OPM_REG = (OPMODEREG != 0);
    localparam bit USE_CIN_REG = (CARRYINREG != 0);
    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

    logic [OPMODE_W-1:0] opm_q;
    logic                cin_d;
    logic                cin_q;
    logic [SUM_W-1:0]    sum_full;
    logic [SUM_W-1:0]    p_full_q;
    logic [P_W-1:0]      p_fb;
    logic                cout_fb;
    logic [SUM_W-1:0]    x_ext;
    logic [SUM_W-1:0]    z_ext;
    logic [SUM_W-1:0]    cin_ext;
    x_sel_e              x_sel;
    z_sel_e              z_sel;
    logic                sub;

    // Carry-in source: raw opmode bit or external port. Taking the raw
    // opmode bit keeps the carry-in register aligned with the opmode register.
    assign cin_d = CIN_FROM_PORT ? carryin : opmode[OPM_CIN_BIT];

    dsp_pipe_reg #(
        .WIDTH   (OPMODE_W),
        .USE_REG (USE_OPM_REG)
    ) u_opmode_reg (
        .clk (clk),
        .rst (rst),
        .ce  (ceopmode),
        .d   (opmode),
        .q   (opm_q)
    );

    dsp_pipe_reg #(
        .WIDTH   (1),
        .USE_REG (USE_CIN_REG)
    ) u_carryin_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cecarryin),
        .d   (cin_d),
        .q   (cin_q)
    );

    assign x_sel   = get_x_sel(opm_q);
    assign z_sel   = get_z_sel(opm_q);
    assign sub     = opm_q[OPM_SUB_BIT];
    assign cin_ext = {{(SUM_W-1){1'b0}}, cin_q};

    // X operand multiplexer; feedback always uses the stored P value
    always_comb begin
        x_ext = '0;
        case (x_sel)
            X_ZERO: x_ext = '0;
            X_M:    x_ext = {{(SUM_W-M_W){1'b0}}, m};
            X_P:    x_ext = {1'b0, p_fb};
            X_DAB:  x_ext = {1'b0, dab};
            default: x_ext = '0;
        endcase
    end

    // Z operand multiplexer; cascade input only exists in the pcin build
    always_comb begin
        z_ext = '0;
        case (z_sel)
            Z_ZERO: z_ext = '0;
`ifdef POST_ADD_PCIN_EN
            Z_PCIN: z_ext = {1'b0, pcin};
`else
            Z_PCIN: z_ext = '0;
`endif
            Z_P:    z_ext = {1'b0, p_fb};
            Z_C:    z_ext = {1'b0, c};
            default: z_ext = '0;
        endcase
    end

    // 49-bit add or subtract; bit 48 is the carry (add) or borrow (sub)
    always_comb begin
        sum_full = '0;
        if (sub) begin
            sum_full = z_ext - (x_ext + cin_ext);
        end else begin
            sum_full = z_ext + x_ext + cin_ext;
        end
    end

    // The P/carryout storage is always registered so that feedback never
    // forms a combinational loop; PREG only decides what drives the outputs.
    dsp_pipe_reg #(
        .WIDTH   (SUM_W),
        .USE_REG (1'b1)
    ) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cep),
        .d   (sum_full),
        .q   (p_full_q)
    );

    assign p_fb    = p_full_q[P_W-1:0];
    assign cout_fb = p_full_q[SUM_W-1];

    // Output selection: registered result or same-cycle combinational result
    generate
        if (PREG != 0) begin : g_p_registered
            assign p        = p_fb;
            assign carryout = cout_fb;
        end else begin : g_p_bypassed
            assign p        = sum_full[P_W-1:0];
            assign carryout = sum_full[SUM_W-1];
        end
    endgenerate

    assign pcout     = p;
    assign carryoutf = carryout;

endmodule

// File: tb/tb_post_adder_preg.sv
// tb_post_adder_preg: directed self-checking bench for post_adder_preg
// with default parameters (PREG=1, OPMODEREG=1, CARRYINREG=1, OPMODE5).
// Because the opmode register is enabled, a new opmode takes effect one
// edge after it is applied; the expectations below account for that.
module tb_post_adder_preg;

    logic        clk;
    logic        rst;
    logic        cep;
    logic        ceopmode;
    logic        cecarryin;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        carryin;
    logic [47:0] p;
    logic [47:0] pcout;
    logic        carryout;
    logic        carryoutf;

    int checks = 0;
    int errors = 0;

    post_adder_preg dut (
        .clk       (clk),
        .rst       (rst),
        .cep       (cep),
        .ceopmode  (ceopmode),
        .cecarryin (cecarryin),
        .opmode    (opmode),
        .m         (m),
        .dab       (dab),
        .c         (c),
`ifdef POST_ADD_PCIN_EN
        .pcin      (pcin),
`endif
        .carryin   (carryin),
        .p         (p),
        .pcout     (pcout),
        .carryout  (carryout),
        .carryoutf (carryoutf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [47:0] exp_p, input logic exp_co);
        chk({tag, "_p"}, p, exp_p);
        chk({tag, "_pcout"}, pcout, exp_p);
        chk({tag, "_co"}, {47'd0, carryout}, {47'd0, exp_co});
        chk({tag, "_cof"}, {47'd0, carryoutf}, {47'd0, exp_co});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cep       = 1'b1;
        ceopmode  = 1'b1;
        cecarryin = 1'b1;
        opmode    = 8'h0D;
        m         = 36'd10;
        dab       = 48'd0;
        c         = 48'd5;
        pcin      = 48'd100;
        carryin   = 1'b0;

        // reset state, with enables active
        tick();
        chk_out("reset", 48'd0, 1'b0);
        rst = 1'b0;

        // X=m, Z=c: first edge loads opmode, result 0 from cleared opmode
        tick();
        chk_out("opm_load", 48'd0, 1'b0);
        tick();
        chk_out("m_plus_c", 48'd15, 1'b0);
        // one-clock operand latency
        m = 36'd20;
        tick();
        chk_out("m_latency", 48'd25, 1'b0);

        // subtract: 3 - 5 in 49 bits
        opmode = 8'h8F; dab = 48'd5; c = 48'd3;
        tick();
        chk("sub_prev", p, 48'd23);
        tick();
        chk_out("sub_neg", 48'hFFFF_FFFF_FFFE, 1'b1);

        // wrap-around: all ones + 1
        opmode = 8'h0F; c = 48'hFFFF_FFFF_FFFF; dab = 48'd1;
        tick();
        chk_out("wrap_prev", 48'hFFFF_FFFF_FFFE, 1'b0);
        tick();
        chk_out("wrap", 48'd0, 1'b1);

        // carry-in from opmode[5]: 2 + 1 + 1
        opmode = 8'h2F; dab = 48'd1; c = 48'd2;
        tick();
        chk("cin_prev", p, 48'd3);
        tick();
        chk_out("cin_add", 48'd4, 1'b0);

        // subtract with carry-in: 10 - (3 + 1)
        opmode = 8'hAF; dab = 48'd3; c = 48'd10;
        tick();
        chk("subcin_prev", p, 48'd14);
        tick();
        chk_out("sub_cin", 48'd6, 1'b0);

        // Z select 1: pcin in the cascade build, zero otherwise
        opmode = 8'h07; dab = 48'd9;
        tick();
        chk("z1_prev", p, 48'd0);
        tick();
`ifdef POST_ADD_PCIN_EN
        chk("z1_pcin", p, 48'd109);
`else
        chk("z1_zero", p, 48'd9);
`endif

        // accumulate X=m, Z=P from reset
        rst = 1'b1;
        #1;
        chk_out("rst_async", 48'd0, 1'b0);
        opmode = 8'h09; m = 36'd1; c = 48'd0;
        #2;
        rst = 1'b0;
        tick();
        chk("acc_opm_load", p, 48'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("acc_%0d", i), p, 48'(i));
        end

        // clock-enable hold on P
        cep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("cep_hold_%0d", i), 48'd4, 1'b0);
        end
        cep = 1'b1;
        tick();
        chk("cep_resume", p, 48'd5);
        tick();
        tick();
        chk("acc_7", p, 48'd7);

        // half-cycle reset pulse between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("rst_pulse", 48'd0, 1'b0);
        #2;
        rst = 1'b0;
        m = 36'd3;
        tick();
        chk("post_rst_opm", p, 48'd0);
        tick();
        chk("post_rst_m", p, 48'd3);
        tick();
        chk("post_rst_2m", p, 48'd6);

        // X feedback from P, Z=c
        opmode = 8'h0E; c = 48'd5;
        tick();
        chk("xfb_prev", p, 48'd9);
        tick();
        chk("xfb", p, 48'd14);

        // opmode register hold with ceopmode=0
        ceopmode = 1'b0;
        opmode = 8'h00;
        tick();
        chk("opm_hold_1", p, 48'd19);
        tick();
        chk("opm_hold_2", p, 48'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
